avg8_seq_ctrl: RTL and testbench

Sequenced 8-input averaging unit. It time-shares one 32-bit adder and one 32-bit right shifter instead of a 7-adder tree and 3 shifters. A start pulse snapshots eight 16-bit operands and a shift amount. A state machine then accumulates the operands, applies three right shifts by the shift amount, and returns a registered 16-bit result with a one-cycle done pulse. It replaces the fully parallel averaging circuit where area matters more than throughput.

---
 rtl/avg8_pkg.sv | 19 +
 rtl/avg8_opbank.sv | 54 +++++
 rtl/avg8_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_avg8_seq_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/avg8_pkg.sv
// Shared types and sizing constants for the sequenced 8-input averaging unit.
package avg8_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SHIFT = 2'd2
    } state_e;

    localparam int NUM_OPS    = 8;
    localparam int NUM_SHIFTS = 3;
    localparam int ACC_W      = 32;
    localparam int IDX_W      = 3;

    // Terminal counter values that end the accumulate and shift phases
    localparam logic [IDX_W-1:0] LAST_OP_IDX    = IDX_W'(NUM_OPS - 1);
    localparam logic [IDX_W-1:0] LAST_SHIFT_IDX = IDX_W'(NUM_SHIFTS - 1);

endpackage

// File: rtl/avg8_opbank.sv
// Operand bank: eight capture registers loaded together on an accepted start,
// read back one at a time through an idx-selected 8:1 mux.
module avg8_opbank
    import avg8_pkg::*;
#(
    parameter int DATAWIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [DATAWIDTH-1:0] c,
    input  logic [DATAWIDTH-1:0] d,
    input  logic [DATAWIDTH-1:0] e,
    input  logic [DATAWIDTH-1:0] f,
    input  logic [DATAWIDTH-1:0] g,
    input  logic [DATAWIDTH-1:0] h,
    input  logic [IDX_W-1:0]     idx,
    output logic [DATAWIDTH-1:0] rd_data
);

    logic [DATAWIDTH-1:0] op_q [NUM_OPS];
    logic [DATAWIDTH-1:0] op_d [NUM_OPS];

    // Next-state of the bank: hold unless the controller accepts a new request
    always_comb begin
        op_d = op_q;
        if (load) begin
            op_d[0] = a;
            op_d[1] = b;
            op_d[2] = c;
            op_d[3] = d;
            op_d[4] = e;
            op_d[5] = f;
            op_d[6] = g;
            op_d[7] = h;
        end
    end

    // Capture registers, cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OPS; i++) begin
                op_q[i] <= '0;
            end
        end else begin
            op_q <= op_d;
        end
    end

    assign rd_data = op_q[idx];

endmodule

// File: rtl/avg8_seq_ctrl.sv
// Sequenced 8-input averager: one shared adder accumulates the captured
// operands over eight cycles, then one shared shifter applies three right
// shifts by the captured amount before the result is registered.
module avg8_seq_ctrl
    import avg8_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int ACCWIDTH  = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [DATAWIDTH-1:0] c,
    input  logic [DATAWIDTH-1:0] d,
    input  logic [DATAWIDTH-1:0] e,
    input  logic [DATAWIDTH-1:0] f,
    input  logic [DATAWIDTH-1:0] g,
    input  logic [DATAWIDTH-1:0] h,
    input  logic [7:0]           sa,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] avg
);

    state_e               state_q, state_d;
    logic [ACCWIDTH-1:0]  acc_q,   acc_d;
    logic [IDX_W-1:0]     idx_q,   idx_d;
    logic [7:0]           sa_q,    sa_d;
    logic                 busy_q,  busy_d;
    logic                 done_q,  done_d;
    logic [DATAWIDTH-1:0] avg_q,   avg_d;

    logic                 load;
    logic [DATAWIDTH-1:0] op_rd;
    logic [ACCWIDTH-1:0]  op_ext;
    logic [ACCWIDTH-1:0]  add_sum;
    logic [ACCWIDTH-1:0]  shr_out;

    assign load = (state_q == IDLE) && start;

    avg8_opbank #(
        .DATAWIDTH (DATAWIDTH)
    ) u_opbank (
        .clk     (Clk),
        .rst_n   (Rst),
        .load    (load),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .e       (e),
        .f       (f),
        .g       (g),
        .h       (h),
        .idx     (idx_q),
        .rd_data (op_rd)
    );

    // Shared datapath: a single adder and a single logical right shifter.
    // A shift amount of 32 or more naturally produces zero.
    always_comb begin
        op_ext  = {{(ACCWIDTH - DATAWIDTH){1'b0}}, op_rd};
        add_sum = acc_q + op_ext;
        shr_out = acc_q >> sa_q;
    end

    // Sequencer: accept in IDLE, eight accumulate steps, three shift steps
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        sa_d    = sa_q;
        avg_d   = avg_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = sa;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = add_sum;
                idx_d = idx_q + 3'd1;
                if (idx_q == LAST_OP_IDX) begin
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = shr_out;
                idx_d = idx_q + 3'd1;
                if (idx_q == LAST_SHIFT_IDX) begin
                    idx_d   = '0;
                    avg_d   = shr_out[DATAWIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Controller, accumulator and output registers
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            sa_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            avg_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            sa_q    <= sa_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            avg_q   <= avg_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign avg  = avg_q;

endmodule

// File: tb/tb_avg8_seq_ctrl.sv
// Self-checking bench for avg8_seq_ctrl: fixed vectors, timing corner cases,
// mid-operation reset and randomized operations against a reference model.
module tb_avg8_seq_ctrl;

    typedef logic [7:0][15:0] ops_t;

    typedef struct {
        string       name;
        ops_t        ops;
        logic [7:0]  sa;
        logic [15:0] exp;
    } vec_t;

    logic        Clk;
    logic        Rst;
    logic        start;
    logic [15:0] a, b, c, d, e, f, g, h;
    logic [7:0]  sa;
    logic        busy;
    logic        done;
    logic [15:0] avg;

    int checks   = 0;
    int failures = 0;

    avg8_seq_ctrl #(
        .DATAWIDTH (16),
        .ACCWIDTH  (32)
    ) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .e     (e),
        .f     (f),
        .g     (g),
        .h     (h),
        .sa    (sa),
        .busy  (busy),
        .done  (done),
        .avg   (avg)
    );

    // 10 ns clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference: sum the eight operands, then divide by 2^sa three times
    function automatic logic [15:0] refAvg(input ops_t ops, input logic [7:0] s);
        longint sum;
        sum = 0;
        for (int i = 0; i < 8; i++) sum += longint'(ops[i]);
        for (int k = 0; k < 3; k++) begin
            if (s >= 8'd32) sum = 0;
            else            sum = sum >> s;
        end
        return sum[15:0];
    endfunction

    function automatic ops_t randomOps();
        ops_t r;
        for (int i = 0; i < 8; i++) r[i] = 16'($urandom);
        return r;
    endfunction

    function automatic ops_t fillOps(input logic [15:0] v);
        ops_t r;
        for (int i = 0; i < 8; i++) r[i] = v;
        return r;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input ops_t ops, input logic [7:0] s);
        a  = ops[0];
        b  = ops[1];
        c  = ops[2];
        d  = ops[3];
        e  = ops[4];
        f  = ops[5];
        g  = ops[6];
        h  = ops[7];
        sa = s;
    endtask

    task automatic startOp(input ops_t ops, input logic [7:0] s);
        applyStimulus(ops, s);
        start = 1'b1;
    endtask

    // Clocks the accepting edge, checks busy for 11 cycles, then checks the
    // done cycle; returns positioned inside the done cycle.
    task automatic waitResult(input logic [15:0] exp, input bit scramble, input string tag);
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            checkOutput({tag, "_busy_high"}, {31'd0, busy}, 32'd1);
            checkOutput({tag, "_done_low"}, {31'd0, done}, 32'd0);
            if (scramble) begin
                applyStimulus(randomOps(), 8'($urandom));
                start = (cyc == 5);
            end
            tick();
        end
        start = 1'b0;
        checkOutput({tag, "_done_pulse"}, {31'd0, done}, 32'd1);
        checkOutput({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_avg"}, {16'd0, avg}, {16'd0, exp});
    endtask

    vec_t vecs[6];

    initial begin
        ops_t ops_v;
        logic [7:0] sa_v;
        logic [15:0] exp_v;

        Rst   = 1'b0;
        start = 1'b0;
        applyStimulus(fillOps(16'h0), 8'd0);

        vecs[0] = '{name: "ones_sa1",   ops: fillOps(16'h0001), sa: 8'd1,  exp: 16'h0001};
        vecs[1] = '{name: "max_sa0",    ops: fillOps(16'hFFFF), sa: 8'd0,  exp: 16'hFFF8};
        vecs[2] = '{name: "max_sa1",    ops: fillOps(16'hFFFF), sa: 8'd1,  exp: 16'hFFFF};
        for (int i = 0; i < 8; i++) ops_v[i] = 16'(10 * (i + 1));
        vecs[3] = '{name: "tens_sa40",  ops: ops_v,             sa: 8'd40, exp: 16'h0000};
        vecs[4] = '{name: "tens_sa1",   ops: ops_v,             sa: 8'd1,  exp: 16'h002D};
        vecs[5] = '{name: "x100_sa2",   ops: fillOps(16'h0100), sa: 8'd2,  exp: 16'h0020};

        // Reset state while Rst is held low
        #3;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_avg", {16'd0, avg}, 32'd0);
        tick();
        tick();
        Rst = 1'b1;
        tick();
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);

        // Fixed vectors
        for (int i = 0; i < 6; i++) begin
            startOp(vecs[i].ops, vecs[i].sa);
            waitResult(vecs[i].exp, 1'b0, vecs[i].name);
            tick();
            checkOutput({vecs[i].name, "_done_width"}, {31'd0, done}, 32'd0);
        end

        // Inputs churn and a stray start while busy must not disturb the result
        startOp(fillOps(16'h0003), 8'd0);
        waitResult(16'h0018, 1'b1, "scramble");
        applyStimulus(fillOps(16'h0), 8'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("scramble_no_extra_done", {31'd0, done}, 32'd0);
            checkOutput("scramble_no_extra_busy", {31'd0, busy}, 32'd0);
        end

        // Back-to-back: new start accepted in the done cycle
        for (int i = 0; i < 8; i++) ops_v[i] = 16'(i + 1);
        startOp(ops_v, 8'd1);
        waitResult(16'h0004, 1'b0, "b2b_first");
        startOp(fillOps(16'h1000), 8'd2);
        waitResult(16'h0200, 1'b0, "b2b_second");
        tick();
        checkOutput("b2b_done_width", {31'd0, done}, 32'd0);

        // Reset during the 4th accumulate cycle aborts the operation
        startOp(fillOps(16'h0777), 8'd1);
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        Rst = 1'b0;
        #1;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        checkOutput("abort_avg", {16'd0, avg}, 32'd0);
        tick();
        Rst = 1'b1;
        tick();
        checkOutput("abort_idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_idle_done", {31'd0, done}, 32'd0);
        startOp(fillOps(16'h0800), 8'd0);
        waitResult(16'h4000, 1'b0, "after_abort");
        tick();

        // Randomized operations, some launched back-to-back
        for (int n = 0; n < 20; n++) begin
            ops_v = randomOps();
            if ($urandom_range(0, 3) == 0) sa_v = 8'($urandom_range(0, 255));
            else                           sa_v = 8'($urandom_range(0, 5));
            exp_v = refAvg(ops_v, sa_v);
            startOp(ops_v, sa_v);
            waitResult(exp_v, ($urandom_range(0, 3) == 0), "random");
            if ($urandom_range(0, 1) == 0) begin
                tick();
                checkOutput("random_done_width", {31'd0, done}, 32'd0);
            end
        end
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
